inst_wait_stage: RTL and testbench

INST_WAIT_STAGE -- requirements
Module: inst_wait_stage

---
 rtl/inst_wait_stage.sv | 133 +++++++++++++
 tb/tb_inst_wait_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_wait_stage.sv
// Instruction wait stage: holds one fetched entry until its bus read data
// returns, then presents {pc, inst, exception info} to decode. A single
// outstanding read is tracked; flushed entries whose read is still in flight
// go to DROP so the late response is swallowed instead of being misattributed.
module inst_wait_stage (
    input  logic        clk,
    input  logic        reset,
    // fetch side
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        cancelled_i,
    input  logic        exc_i,
    input  logic        exc_miss_i,
    input  logic [4:0]  exccode_i,
    output logic        ready_o,
    // instruction bus response
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    // decode side
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    input  logic        ready_i,
    // flush from commit
    input  logic        cancel_i
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DROP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        exc_q, exc_d;
    logic        exc_miss_q, exc_miss_d;
    logic [4:0]  exccode_q, exccode_d;

    logic        accept;
    logic        kill_new;

    // A held FULL entry frees the slot either by being consumed or by a flush,
    // so a new entry can be taken the same cycle (no bubble).
    assign ready_o  = (state_q == S_EMPTY) ||
                      (state_q == S_FULL && ready_i) ||
                      (state_q == S_FULL && cancel_i);
    assign accept   = valid_i && ready_o;
    assign kill_new = cancelled_i || cancel_i;

    // Next-state and capture logic for the single held entry.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        exc_d      = exc_q;
        exc_miss_d = exc_miss_q;
        exccode_d  = exccode_q;

        unique case (state_q)
            S_EMPTY, S_FULL: begin
                // Held entry leaves when decode takes it or it is flushed.
                if (state_q == S_FULL && (ready_i || cancel_i)) begin
                    state_d = S_EMPTY;
                end
                if (accept) begin
                    pc_d       = pc_i;
                    exc_d      = exc_i;
                    exc_miss_d = exc_miss_i;
                    exccode_d  = exccode_i;
                    if (exc_i) begin
                        // Faulting fetch never issued a bus read.
                        inst_d  = 32'd0;
                        state_d = kill_new ? S_EMPTY : S_FULL;
                    end else if (inst_data_ok) begin
                        inst_d  = inst_rdata;
                        state_d = kill_new ? S_EMPTY : S_FULL;
                    end else begin
                        inst_d  = 32'd0;
                        state_d = kill_new ? S_DROP : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    inst_d  = inst_rdata;
                    state_d = cancel_i ? S_EMPTY : S_FULL;
                end else if (cancel_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // Response belongs to a flushed entry; discard it.
                if (inst_data_ok) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // State and output registers; reset clears everything and beats all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            pc_q       <= 32'd0;
            inst_q     <= 32'd0;
            exc_q      <= 1'b0;
            exc_miss_q <= 1'b0;
            exccode_q  <= 5'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            exc_q      <= exc_d;
            exc_miss_q <= exc_miss_d;
            exccode_q  <= exccode_d;
        end
    end

    assign valid_o    = (state_q == S_FULL);
    assign pc_o       = pc_q;
    assign inst_o     = inst_q;
    assign exc_o      = exc_q;
    assign exc_miss_o = exc_miss_q;
    assign exccode_o  = exccode_q;

endmodule

// File: tb/tb_inst_wait_stage.sv
// Directed bench for inst_wait_stage: a cycle-by-cycle vector table with
// hand-computed expectations, plus a back-to-back streaming sequence.
module tb_inst_wait_stage;

    logic        clk;
    logic        reset;
    logic        valid_i, cancelled_i, exc_i, exc_miss_i;
    logic [31:0] pc_i;
    logic [4:0]  exccode_i;
    logic        ready_o;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        valid_o, exc_o, exc_miss_o;
    logic [31:0] pc_o, inst_o;
    logic [4:0]  exccode_o;
    logic        ready_i, cancel_i;

    int errors = 0;
    int checks = 0;

    inst_wait_stage dut (
        .clk(clk), .reset(reset),
        .valid_i(valid_i), .pc_i(pc_i), .cancelled_i(cancelled_i),
        .exc_i(exc_i), .exc_miss_i(exc_miss_i), .exccode_i(exccode_i),
        .ready_o(ready_o),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .exc_o(exc_o),
        .exc_miss_o(exc_miss_o), .exccode_o(exccode_o), .ready_i(ready_i),
        .cancel_i(cancel_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock cycle: inputs driven before the edge, ready_o
    // expected before the edge, registered outputs expected after it.
    typedef struct {
        logic        rst, vld;
        logic [31:0] pc;
        logic        cnl, exc, exm;
        logic [4:0]  code;
        logic        dok;
        logic [31:0] rdata;
        logic        rdy, cnc;
        logic        erdy, evo;
        logic [31:0] epc, einst;
        logic        eexc, eexm;
        logic [4:0]  ecode;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic vld, input logic [31:0] pc,
                       input logic cnl, input logic exc, input logic exm,
                       input logic [4:0] code, input logic dok, input logic [31:0] rdata,
                       input logic rdy, input logic cnc, input logic erdy, input logic evo,
                       input logic [31:0] epc, input logic [31:0] einst,
                       input logic eexc, input logic eexm, input logic [4:0] ecode);
        vec_t v;
        v.rst = rst; v.vld = vld; v.pc = pc; v.cnl = cnl; v.exc = exc; v.exm = exm;
        v.code = code; v.dok = dok; v.rdata = rdata; v.rdy = rdy; v.cnc = cnc;
        v.erdy = erdy; v.evo = evo; v.epc = epc; v.einst = einst;
        v.eexc = eexc; v.eexm = eexm; v.ecode = ecode;
        vq.push_back(v);
    endtask

    // Shorthand for a cycle with no entry offered and no visible output.
    task automatic idle(input logic dok, input logic [31:0] rdata, input logic rdy,
                        input logic cnc, input logic erdy);
        add(0, 0, 0, 0, 0, 0, 0, dok, rdata, rdy, cnc, erdy, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        valid_i = 0; pc_i = 0; cancelled_i = 0; exc_i = 0; exc_miss_i = 0;
        exccode_i = 0; inst_data_ok = 0; inst_rdata = 0; ready_i = 0; cancel_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive_idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_o", valid_o, 0);
        chk("reset pc_o", pc_o, 0);
        chk("reset inst_o", inst_o, 0);
        chk("reset exc_o", exc_o, 0);
        chk("reset exc_miss_o", exc_miss_o, 0);
        chk("reset exccode_o", exccode_o, 0);
        @(negedge clk);
        reset = 0;

        // Basic fetch: data two cycles after accept.
        add(0, 1, 'hBFC00000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 'h3C1D0001, 1, 0, 0, 1, 'hBFC00000, 'h3C1D0001, 0, 0, 0);
        idle(0, 0, 1, 0, 1);
        // Same-cycle data, back-to-back entries.
        add(0, 1, 'h80000100, 0, 0, 0, 0, 1, 'h24020005, 1, 0, 1, 1, 'h80000100, 'h24020005, 0, 0, 0);
        add(0, 1, 'h80000104, 0, 0, 0, 0, 1, 'h24030006, 1, 0, 1, 1, 'h80000104, 'h24030006, 0, 0, 0);
        add(0, 1, 'h80000108, 0, 0, 0, 0, 1, 'h00431020, 1, 0, 1, 1, 'h80000108, 'h00431020, 0, 0, 0);
        // FULL consumed while a new entry without data is accepted -> WAIT.
        add(0, 1, 'h8000010C, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 'h8C440000, 1, 0, 0, 1, 'h8000010C, 'h8C440000, 0, 0, 0);
        idle(0, 0, 1, 0, 1);
        // Address-error exception: no bus data needed.
        add(0, 1, 'h80000001, 0, 1, 0, 4, 0, 0, 1, 0, 1, 1, 'h80000001, 0, 1, 0, 4);
        idle(0, 0, 1, 0, 1);
        // TLB refill exception, then decode stalls 4 cycles with noise on inputs.
        add(0, 1, 'h00400000, 0, 1, 1, 2, 0, 0, 0, 0, 1, 1, 'h00400000, 0, 1, 1, 2);
        for (int k = 0; k < 4; k++)
            add(0, 1, 'hDEAD0000, 0, 0, 0, 0, 1, 'hFFFFFFFF, 0, 0, 0, 1, 'h00400000, 0, 1, 1, 2);
        idle(0, 0, 1, 0, 1);
        // Flush in WAIT, data 3 cycles later; DROP ignores cancel and new entries.
        add(0, 1, 'h80000200, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 1, 1, 0);
        idle(0, 0, 1, 1, 0);
        add(0, 1, 'h80000300, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 'h11111111, 1, 0, 0);
        idle(0, 0, 1, 0, 1);
        // Flush in WAIT coincident with data -> EMPTY.
        add(0, 1, 'h80000400, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 'h22222222, 1, 1, 0);
        idle(0, 0, 1, 0, 1);
        // Pre-cancelled entry without data -> DROP until data.
        add(0, 1, 'h80000500, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 1, 0, 0);
        idle(1, 'h33333333, 1, 0, 0);
        // Exception entry flushed on accept -> EMPTY; cancelled entry with data -> EMPTY.
        add(0, 1, 'h80000600, 0, 1, 0, 4, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'h80000700, 1, 0, 0, 0, 1, 'h44444444, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        // Stray data in EMPTY is ignored.
        idle(1, 'h55555555, 1, 0, 1);
        idle(0, 0, 1, 0, 1);
        // FULL flushed with no new entry.
        add(0, 1, 'h80000800, 0, 0, 0, 0, 1, 'h66666666, 0, 0, 1, 1, 'h80000800, 'h66666666, 0, 0, 0);
        idle(0, 0, 0, 1, 1);
        // FULL flushed while a new entry with data arrives -> new entry also dropped.
        add(0, 1, 'h80000900, 0, 0, 0, 0, 1, 'h77777777, 0, 0, 1, 1, 'h80000900, 'h77777777, 0, 0, 0);
        add(0, 1, 'h80000A00, 0, 0, 0, 0, 1, 'h88888888, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 1, 0, 1);
        // Reset during WAIT, then a stray response.
        add(0, 1, 'h80000B00, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 'h99999999, 1, 0, 1);
        idle(0, 0, 1, 0, 1);
        // Reset during FULL overrides an offered entry.
        add(0, 1, 'h80000C00, 0, 1, 1, 7, 0, 0, 0, 0, 1, 1, 'h80000C00, 0, 1, 1, 7);
        add(1, 1, 'h80000D00, 0, 0, 0, 0, 1, 'hAAAAAAAA, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 1, 0, 1);

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst; valid_i = vq[i].vld; pc_i = vq[i].pc;
            cancelled_i = vq[i].cnl; exc_i = vq[i].exc; exc_miss_i = vq[i].exm;
            exccode_i = vq[i].code; inst_data_ok = vq[i].dok; inst_rdata = vq[i].rdata;
            ready_i = vq[i].rdy; cancel_i = vq[i].cnc;
            #1;
            chk($sformatf("row%0d ready_o", i), ready_o, vq[i].erdy);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d valid_o", i), valid_o, vq[i].evo);
            if (vq[i].evo || vq[i].rst) begin
                chk($sformatf("row%0d pc_o", i), pc_o, vq[i].epc);
                chk($sformatf("row%0d inst_o", i), inst_o, vq[i].einst);
                chk($sformatf("row%0d exc_o", i), exc_o, vq[i].eexc);
                chk($sformatf("row%0d exc_miss_o", i), exc_miss_o, vq[i].eexm);
                chk($sformatf("row%0d exccode_o", i), exccode_o, vq[i].ecode);
            end
        end
        reset = 0;

        // Streaming: one entry per cycle with same-cycle data keeps valid_o high.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive_idle();
            valid_i = 1; pc_i = 32'h90000000 + 32'(4 * k);
            inst_data_ok = 1; inst_rdata = 32'h01010101 * 32'(k + 1); ready_i = 1;
            #1;
            chk($sformatf("stream%0d ready_o", k), ready_o, 1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d valid_o", k), valid_o, 1);
            chk($sformatf("stream%0d pc_o", k), pc_o, 32'h90000000 + 32'(4 * k));
            chk($sformatf("stream%0d inst_o", k), inst_o, 32'h01010101 * 32'(k + 1));
        end
        @(negedge clk);
        drive_idle();
        ready_i = 1;
        @(posedge clk);
        #1;
        chk("stream drain valid_o", valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
